gate_sweep_controller: RTL and testbench



---
 rtl/gate_sweep_controller.sv | 139 +++++++++++++
 tb/tb_gate_sweep_controller.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_controller.sv
// Exhaustive truth-table sweeper for a 3-input combinational gate (A,B,C -> F).
// Drives vectors 0..7 in order, holds each SETTLE_CYCLES+1 cycles, samples F on the last
// of them, then compares the 8 captured bits against EXPECT and reports pass/fail.
// Ports: clk, rst_n (async, active-low); start (sampled in IDLE), abort (honoured while busy),
//        f_in (gate output); drive_a/b/c (vector bits 2/1/0), busy, done (1-cycle pulse),
//        pass, captured[7:0], fail_mask[7:0] (held until the next accepted start).
module gate_sweep_controller #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  EXPECT        = 8'h54
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       f_in,
  output logic       drive_a,
  output logic       drive_b,
  output logic       drive_c,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] captured,
  output logic [7:0] fail_mask
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // With zero settle time every vector goes straight to SAMPLE; the counter is then unused.
  localparam int unsigned CNT_INIT_I = (SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1;
  localparam logic [3:0]  CNT_INIT   = CNT_INIT_I[3:0];
  localparam state_t      S_FIRST    = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;

  state_t     r_state;
  logic [2:0] r_idx;
  logic [3:0] r_cnt;
  logic [2:0] r_drive;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [7:0] r_captured;
  logic [7:0] r_fail_mask;

  // Full result as it will look once the last vector's bit lands, so pass/fail_mask are
  // already valid in the DONE cycle.
  logic [7:0] w_final;
  assign w_final = {f_in, r_captured[6:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= 3'd0;
      r_cnt       <= 4'd0;
      r_drive     <= 3'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_captured  <= 8'h00;
      r_fail_mask <= 8'h00;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // abort is irrelevant here, so start always wins
          if (start) begin
            r_captured  <= 8'h00;
            r_pass      <= 1'b0;
            r_fail_mask <= 8'h00;
            r_idx       <= 3'd0;
            r_cnt       <= CNT_INIT;
            r_drive     <= 3'd0;
            r_busy      <= 1'b1;
            r_state     <= S_FIRST;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_idx   <= 3'd0;
            r_cnt   <= 4'd0;
            r_drive <= 3'd0;
            r_busy  <= 1'b0;
          end else if (r_cnt == 4'd0) begin
            r_state <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_SAMPLE: begin
          if (abort) begin
            // the bit of the aborted sample cycle is deliberately not written
            r_state <= S_IDLE;
            r_idx   <= 3'd0;
            r_cnt   <= 4'd0;
            r_drive <= 3'd0;
            r_busy  <= 1'b0;
          end else begin
            r_captured[r_idx] <= f_in;
            if (r_idx == 3'd7) begin
              r_state     <= S_DONE;
              r_idx       <= 3'd0;
              r_drive     <= 3'd0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_pass      <= (w_final == EXPECT);
              r_fail_mask <= w_final ^ EXPECT;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_drive <= r_idx + 3'd1;
              r_cnt   <= CNT_INIT;
              r_state <= S_FIRST;
            end
          end
        end
        S_DONE: begin
          // start is ignored here; back-to-back sweeps get one IDLE cycle between them
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign drive_a   = r_drive[2];
  assign drive_b   = r_drive[1];
  assign drive_c   = r_drive[0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign captured  = r_captured;
  assign fail_mask = r_fail_mask;

endmodule

// File: tb/tb_gate_sweep_controller.sv
// Self-checking bench for gate_sweep_controller: one instance with SETTLE_CYCLES=2 and one
// with SETTLE_CYCLES=0, each driving a behavioural POS gate (or a faulty AND3 stand-in).
// Expected sweep results are queued when a start is driven and popped on each done pulse.
module tb_gate_sweep_controller;

  localparam logic [7:0] EXP_MASK = 8'h54;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, abort, start_z, abort_z, faulty;

  logic       da, db, dc, busy, done, pass;
  logic [7:0] cap, fm;
  logic       f_in;
  logic       da_z, db_z, dc_z, busy_z, done_z, pass_z;
  logic [7:0] cap_z, fm_z;
  logic       f_in_z;

  typedef struct {
    logic [7:0] cap;
    logic [7:0] fm;
    logic       ps;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // POS gate with maxterms 0,1,3,5,7; faulty variant is a plain AND3
  function automatic logic gate_f(input logic [2:0] v, input logic flt);
    logic a, b, c;
    a = v[2]; b = v[1]; c = v[0];
    if (flt) return a & b & c;
    return (a | b | c) & (a | b | ~c) & (a | ~b | ~c) & (~a | b | ~c) & (~a | ~b | ~c);
  endfunction

  function automatic exp_t model_result(input logic flt);
    exp_t e;
    logic [2:0] v;
    e.cap = 8'h00;
    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      e.cap[k] = gate_f(v, flt);
    end
    e.fm = e.cap ^ EXP_MASK;
    e.ps = (e.cap == EXP_MASK);
    return e;
  endfunction

  assign f_in   = gate_f({da, db, dc}, faulty);
  assign f_in_z = gate_f({da_z, db_z, dc_z}, faulty);

  gate_sweep_controller #(.SETTLE_CYCLES(2), .EXPECT(8'h54)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .f_in(f_in),
    .drive_a(da), .drive_b(db), .drive_c(dc), .busy(busy), .done(done),
    .pass(pass), .captured(cap), .fail_mask(fm)
  );

  gate_sweep_controller #(.SETTLE_CYCLES(0), .EXPECT(8'h54)) dut_z (
    .clk(clk), .rst_n(rst_n), .start(start_z), .abort(abort_z), .f_in(f_in_z),
    .drive_a(da_z), .drive_b(db_z), .drive_c(dc_z), .busy(busy_z), .done(done_z),
    .pass(pass_z), .captured(cap_z), .fail_mask(fm_z)
  );

  task automatic test_reset();
    n_cmp++;
    if ({da, db, dc, busy, done, pass, cap, fm} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_s2: outputs=%h required 0", {da, db, dc, busy, done, pass, cap, fm});
    end
    n_cmp++;
    if ({da_z, db_z, dc_z, busy_z, done_z, pass_z, cap_z, fm_z} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_s0: outputs=%h required 0",
               {da_z, db_z, dc_z, busy_z, done_z, pass_z, cap_z, fm_z});
    end
  endtask

  // Runs one full sweep on the chosen instance and checks every cycle of it.
  task automatic sweep_and_check(input int s, input bit on_zero, input bit flt, input string name);
    exp_t       e;
    int         done_cyc, k;
    bit         seen;
    logic [2:0] exp_drv, o_drv;
    logic       exp_busy, o_busy, o_done, o_pass;
    logic [7:0] o_cap, o_fm;
    done_cyc = 8 * (s + 1) + 1;
    seen = 1'b0;
    e = '{cap: 8'h00, fm: 8'h00, ps: 1'b0};
    @(negedge clk);
    faulty = flt;
    if (on_zero) start_z = 1'b1; else start = 1'b1;
    q.push_back(model_result(flt));
    for (int cyc = 1; cyc <= done_cyc + 3; cyc++) begin
      @(negedge clk);
      start = 1'b0; start_z = 1'b0;
      if (on_zero) begin
        o_drv = {da_z, db_z, dc_z}; o_busy = busy_z; o_done = done_z;
        o_pass = pass_z; o_cap = cap_z; o_fm = fm_z;
      end else begin
        o_drv = {da, db, dc}; o_busy = busy; o_done = done;
        o_pass = pass; o_cap = cap; o_fm = fm;
      end
      if (cyc <= 8 * (s + 1)) begin
        k = (cyc - 1) / (s + 1);
        exp_drv = k[2:0];
        exp_busy = 1'b1;
      end else begin
        exp_drv = 3'd0;
        exp_busy = 1'b0;
      end
      n_cmp++;
      if (o_drv !== exp_drv || o_busy !== exp_busy || o_done !== (cyc == done_cyc)) begin
        n_err++;
        $display("FAIL %s_timing cyc=%0d: drive=%b busy=%b done=%b required drive=%b busy=%b done=%b",
                 name, cyc, o_drv, o_busy, o_done, exp_drv, exp_busy, (cyc == done_cyc));
      end
      if (o_done === 1'b1) begin
        seen = 1'b1;
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL %s_sb: done with empty scoreboard", name);
        end else begin
          e = q.pop_front();
          if (o_cap !== e.cap || o_fm !== e.fm || o_pass !== e.ps) begin
            n_err++;
            $display("FAIL %s_result: captured=%h fail_mask=%h pass=%b required %h %h %b",
                     name, o_cap, o_fm, o_pass, e.cap, e.fm, e.ps);
          end
        end
      end
      if (cyc == done_cyc + 3 && seen) begin
        n_cmp++;
        if (o_cap !== e.cap || o_fm !== e.fm || o_pass !== e.ps) begin
          n_err++;
          $display("FAIL %s_hold: captured=%h fail_mask=%h pass=%b required %h %h %b",
                   name, o_cap, o_fm, o_pass, e.cap, e.fm, e.ps);
        end
      end
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL %s_done_timeout: no done within %0d cycles", name, done_cyc + 3);
      if (q.size() > 0) void'(q.pop_front());
    end
  endtask

  task automatic test_pos_correct();
    sweep_and_check(2, 1'b0, 1'b0, "pos_s2");
  endtask

  task automatic test_pos_faulty();
    sweep_and_check(2, 1'b0, 1'b1, "and3_s2");
  endtask

  task automatic test_settle_zero();
    sweep_and_check(0, 1'b1, 1'b0, "pos_s0");
  endtask

  task automatic test_abort();
    bit done_seen;
    @(negedge clk);
    faulty = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 2; cyc <= 12; cyc++) @(negedge clk);
    // cycle 12: SAMPLE of vector 3
    n_cmp++;
    if (busy !== 1'b1 || {da, db, dc} !== 3'd3) begin
      n_err++;
      $display("FAIL abort_pre: busy=%b drive=%b required 1 011", busy, {da, db, dc});
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || {da, db, dc} !== 3'd0 || done !== 1'b0 || cap !== 8'h04 || pass !== 1'b0) begin
      n_err++;
      $display("FAIL abort_post: busy=%b drive=%b done=%b captured=%h pass=%b required 0 000 0 04 0",
               busy, {da, db, dc}, done, cap, pass);
    end
    done_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
    end
    n_cmp++;
    if (done_seen !== 1'b0 || cap !== 8'h04) begin
      n_err++;
      $display("FAIL abort_quiet: activity=%b captured=%h required 0 04", done_seen, cap);
    end
    sweep_and_check(2, 1'b0, 1'b0, "post_abort");
  endtask

  task automatic test_start_abort_idle();
    exp_t e;
    bit   seen;
    @(negedge clk);
    faulty = 1'b0; start = 1'b1; abort = 1'b1;
    q.push_back(model_result(1'b0));
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL start_vs_abort: busy=%b required 1", busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        e = q.pop_front();
        n_cmp++;
        if (pass !== e.ps || cap !== e.cap) begin
          n_err++;
          $display("FAIL start_vs_abort_result: captured=%h pass=%b required %h %b", cap, pass, e.cap, e.ps);
        end
      end
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL start_vs_abort_timeout: no done");
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    int         p, k;
    logic [2:0] exp_drv;
    logic       exp_busy;
    @(negedge clk);
    faulty = 1'b0; start = 1'b1;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({da, db, dc, busy, done, pass, cap, fm} !== 22'd0) begin
      n_err++;
      $display("FAIL midreset_async: outputs=%h required 0", {da, db, dc, busy, done, pass, cap, fm});
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({da, db, dc, busy, done, pass, cap, fm} !== 22'd0) begin
      n_err++;
      $display("FAIL midreset_held: outputs=%h required 0", {da, db, dc, busy, done, pass, cap, fm});
    end
    // release here: the next edge accepts the held start (cycle 0)
    rst_n = 1'b1;
    q.push_back(model_result(1'b0));
    for (int cyc = 1; cyc <= 77; cyc++) begin
      @(negedge clk);
      p = cyc % 26;
      if (p == 0) q.push_back(model_result(1'b0));
      exp_busy = (p >= 1 && p <= 24);
      k = exp_busy ? (p - 1) / 3 : 0;
      exp_drv = k[2:0];
      n_cmp++;
      if ({da, db, dc} !== exp_drv || busy !== exp_busy || done !== (p == 25)) begin
        n_err++;
        $display("FAIL b2b_timing cyc=%0d: drive=%b busy=%b done=%b required %b %b %b",
                 cyc, {da, db, dc}, busy, done, exp_drv, exp_busy, (p == 25));
      end
      if (done === 1'b1 && q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (cap !== e.cap || fm !== e.fm || pass !== e.ps) begin
          n_err++;
          $display("FAIL b2b_result cyc=%0d: captured=%h fail_mask=%h pass=%b required %h %h %b",
                   cyc, cap, fm, pass, e.cap, e.fm, e.ps);
        end
      end
    end
    start = 1'b0;
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_sb: %0d sweeps left unfinished, required 0", q.size());
      q.delete();
    end
    repeat (30) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    start_z = 1'b0; abort_z = 1'b0; faulty = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_pos_correct();
    test_pos_faulty();
    test_settle_zero();
    test_abort();
    test_start_abort_idle();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
